// File: rtl/mcc_pkg.sv
// Shared widths, responder state encodings and constants for the MCC memory responder.
package mcc_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int MEMORY_ADDR_WIDTH = 32;
    localparam int MEMORY_DATA_WIDTH = 32;
    localparam int COUNT_WIDTH       = 16;
    localparam int STATE_WIDTH       = 2;

    localparam logic [MEMORY_DATA_WIDTH-1:0] OOR_READ_VALUE = 32'hDEAD_BEEF;

    typedef enum logic [STATE_WIDTH-1:0] {
        RESP_IDLE = 2'd0,
        RESP_WAIT = 2'd1,
        RESP_DONE = 2'd2
    } resp_state_e;

endpackage

// File: rtl/mcc_sram.sv
// Single-port synchronous word array: one read or write per enabled edge, registered read data.
module mcc_sram
    import mcc_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_BITS-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: the array has no reset so it can map onto RAM macros; contents survive rstn.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read data only moves on a read, so a write leaves the last read word on the bus.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mcc_mem_responder.sv
// MCC main-memory responder: four-phase en/rdy handshake, fixed latency, saturating debug counters.
module mcc_mem_responder
    import mcc_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 3
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [MEMORY_ADDR_WIDTH-1:0] mem_addr,
    input  logic                         mem_en,
    input  logic                         mem_we,
    input  logic [MEMORY_DATA_WIDTH-1:0] mem_data_out,
    output logic [MEMORY_DATA_WIDTH-1:0] mem_data_in,
    output logic                         mem_rdy,
    output logic                         mem_err,
    output logic [COUNT_WIDTH-1:0]       rd_count,
    output logic [COUNT_WIDTH-1:0]       wr_count
);

    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0]       LAT_LOAD  = LAT_W'(LATENCY - 1);
    localparam logic [LAT_W-1:0]       LAT_ONE   = LAT_W'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    resp_state_e            state_q, state_d;
    logic [LAT_W-1:0]       lat_q, lat_d;

    logic [ADDR_BITS-1:0]   idx_q;
    logic                   in_range_q;
    logic                   we_q;
    logic [DATA_WIDTH-1:0]  wdata_q;

    logic                   rdy_q;
    logic                   err_q;
    logic                   oor_sel_q;
    logic [COUNT_WIDTH-1:0] rd_count_q;
    logic [COUNT_WIDTH-1:0] wr_count_q;

    logic                   accept;
    logic                   complete;
    logic                   addr_in_range;
    logic [DATA_WIDTH-1:0]  sram_rdata;

    assign addr_in_range = (mem_addr[MEMORY_ADDR_WIDTH-1:ADDR_BITS] == '0);
    assign accept        = (state_q == RESP_IDLE) && mem_en;
    assign complete      = (state_q == RESP_WAIT) && (lat_q == '0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            RESP_IDLE: begin
                if (mem_en) begin
                    state_d = RESP_WAIT;
                    lat_d   = LAT_LOAD;
                end
            end
            RESP_WAIT: begin
                if (lat_q == '0) begin
                    state_d = RESP_DONE;
                end else begin
                    lat_d = lat_q - LAT_ONE;
                end
            end
            RESP_DONE: begin
                if (!mem_en) begin
                    state_d = RESP_IDLE;
                end
            end
            default: state_d = RESP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RESP_IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Request is captured once at acceptance; inputs are ignored until back in IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q      <= '0;
            in_range_q <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
        end else if (accept) begin
            idx_q      <= mem_addr[ADDR_BITS-1:0];
            in_range_q <= addr_in_range;
            we_q       <= mem_we;
            wdata_q    <= mem_data_out;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            oor_sel_q  <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (complete) begin
            rdy_q <= 1'b1;
            err_q <= !in_range_q;
            if (we_q) begin
                if (wr_count_q != '1) wr_count_q <= wr_count_q + COUNT_ONE;
            end else begin
                oor_sel_q <= !in_range_q;
                if (rd_count_q != '1) rd_count_q <= rd_count_q + COUNT_ONE;
            end
        end else if ((state_q == RESP_DONE) && !mem_en) begin
            rdy_q <= 1'b0;
            err_q <= 1'b0;
        end
    end

    // Out-of-range requests never touch the array.
    mcc_sram #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_sram (
        .clk     (clk),
        .rstn    (rstn),
        .en_i    (complete && in_range_q),
        .we_i    (we_q),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (sram_rdata)
    );

    assign mem_data_in = oor_sel_q ? OOR_READ_VALUE : sram_rdata;
    assign mem_rdy     = rdy_q;
    assign mem_err     = err_q;
    assign rd_count    = rd_count_q;
    assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_mcc_mem_responder.sv
// Randomized self-checking bench for mcc_mem_responder against a transaction-level memory model.
module tb_mcc_mem_responder;

    localparam int LATENCY = 3;
    localparam int DEPTH   = 256;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] mem_addr;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;
    logic        mem_rdy;
    logic        mem_err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    always #5 clk = ~clk;

    mcc_mem_responder #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (8),
        .LATENCY   (LATENCY)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .mem_addr     (mem_addr),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_rdy      (mem_rdy),
        .mem_err      (mem_err),
        .rd_count     (rd_count),
        .wr_count     (wr_count)
    );

    // Reference model: word array with written-flags, saturating counts, last read value.
    logic [31:0] ref_mem   [DEPTH];
    bit          ref_valid [DEPTH];
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_din;
    bit          din_known;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_rd    = 0;
        exp_wr    = 0;
        exp_din   = 32'h0;
        din_known = 1'b1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        mem_en = 1'b0;
        model_reset();
        #1;
        check("rst_rdy", 32'(mem_rdy), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        check("rst_din", mem_data_in, 32'h0);
        check("rst_rdcnt", 32'(rd_count), 32'd0);
        check("rst_wrcnt", 32'(wr_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // One complete handshake; hold = cycles en stays high after rdy, early = drop en after acceptance.
    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] data,
                          input int hold, input bit early);
        bit in_range;
        int cyc;
        in_range = (addr[31:8] == 24'h0);

        @(negedge clk);
        mem_en       = 1'b1;
        mem_we       = we;
        mem_addr     = addr;
        mem_data_out = data;
        @(negedge clk);
        cyc = 0;
        if (early) mem_en = 1'b0;
        // Scramble the request inputs: the latched copy must be used.
        mem_addr     = $urandom;
        mem_we       = ~we;
        mem_data_out = $urandom;
        while (!mem_rdy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rdy_latency", 32'(cyc), 32'(LATENCY));

        if (we) begin
            if (in_range) begin
                ref_mem[addr[7:0]]   = data;
                ref_valid[addr[7:0]] = 1'b1;
            end
            if (exp_wr < 16'hFFFF) exp_wr++;
        end else begin
            if (!in_range) begin
                exp_din   = 32'hDEAD_BEEF;
                din_known = 1'b1;
            end else begin
                exp_din   = ref_mem[addr[7:0]];
                din_known = ref_valid[addr[7:0]];
            end
            if (exp_rd < 16'hFFFF) exp_rd++;
        end

        check("err", 32'(mem_err), 32'(!in_range));
        if (din_known) check("data_in", mem_data_in, exp_din);
        check("rd_count", 32'(rd_count), 32'(exp_rd));
        check("wr_count", 32'(wr_count), 32'(exp_wr));

        if (early) begin
            @(negedge clk);
            check("rdy_one_cycle", 32'(mem_rdy), 32'd0);
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_rdy", 32'(mem_rdy), 32'd1);
                check("hold_err", 32'(mem_err), 32'(!in_range));
                if (din_known) check("hold_data", mem_data_in, exp_din);
                check("hold_rdcnt", 32'(rd_count), 32'(exp_rd));
                check("hold_wrcnt", 32'(wr_count), 32'(exp_wr));
            end
            mem_en = 1'b0;
            @(negedge clk);
            check("rdy_fall", 32'(mem_rdy), 32'd0);
            check("err_fall", 32'(mem_err), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a;
        mem_en = 1'b0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_data_out = '0;
        for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
        apply_reset();

        // Write then read, in range.
        do_txn(32'd5, 1'b1, 32'h1234_5678, 0, 1'b0);
        do_txn(32'd5, 1'b0, 32'h0, 0, 1'b0);

        // Out-of-range read and dropped write; word 0 keeps its prior value.
        do_txn(32'd0, 1'b1, 32'h0BAD_F00D, 0, 1'b0);
        do_txn(32'h0000_0100, 1'b0, 32'h0, 0, 1'b0);
        do_txn(32'h0000_0100, 1'b1, 32'hAAAA_AAAA, 0, 1'b0);
        do_txn(32'd0, 1'b0, 32'h0, 0, 1'b0);

        // Held handshake, then early drop on a write followed by its readback.
        do_txn(32'd5, 1'b0, 32'h0, 4, 1'b0);
        do_txn(32'd9, 1'b1, 32'h5A5A_0009, 0, 1'b1);
        do_txn(32'd9, 1'b0, 32'h0, 1, 1'b0);

        // Reset mid-WAIT drops the write to word 7.
        do_txn(32'd7, 1'b1, 32'h1111_1111, 0, 1'b0);
        @(negedge clk);
        mem_en = 1'b1;
        mem_we = 1'b1;
        mem_addr = 32'd7;
        mem_data_out = 32'hCAFE_0000;
        @(negedge clk);
        apply_reset();
        do_txn(32'd7, 1'b0, 32'h0, 0, 1'b0);

        // Randomized traffic over a small window plus occasional out-of-range addresses.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_0100;
            else a = 32'($urandom_range(0, 15));
            do_txn(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3),
                   ($urandom_range(0, 4) == 0));
        end

        // Write-counter saturation.
        @(negedge clk);
        force dut.wr_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.wr_count_q;
        exp_wr = 16'hFFFE;
        for (int n = 0; n < 3; n++) begin
            do_txn(32'($urandom_range(0, 15)), 1'b1, $urandom, 0, 1'b0);
        end
        check("wr_sat", 32'(wr_count), 32'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
